freq_gate_ctrl: RTL and testbench
=================================

# freq_gate_ctrl

Gate-timing and result-latch controller for the frequency meter, directly upstream of the 4-digit BCD counter. It runs on the reference clock and generates the counter's count_ena and count_clear. After each gate window closes, it captures the counter's four BCD digits into stable display registers, so the display stage never sees a counting value. One measurement runs per gate window: continuously while run is high, otherwise it stops after the current measurement.

## Interface
- GATE_CYCLES, 50_000_000: reference-clock cycles count_ena is high per measurement (1 s at 50 MHz); ≥1
- CLEAR_CYCLES, 2: cycles count_clear is held high before each gate; ≥1
- SETTLE_CYCLES, 4: cycles after gate close before latching, so counter digits are stable; ≥1
- clk  in  1  reference clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- run  in  1  level; high = measure continuously
- count3..count0  in  4 each  BCD digits from counter (thousands..units); 4'hE on all = counter overflow
- count_ena  out  1  gate to counter
- count_clear  out  1  clear to counter (counter treats it as asynchronous)
- disp3..disp0  out  4 each  latched result digits
- overflow  out  1  latched: last result overflowed
- valid  out  1  one-cycle pulse: new result in disp*/overflow
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH. A single down-counter timer is shared, loaded on each state entry.
- IDLE: count_clear=1, count_ena=0. Goes to CLEAR on the first cycle run=1 is sampled.
- CLEAR: count_clear=1 for exactly CLEAR_CYCLES cycles, then GATE.
- GATE: count_ena=1, count_clear=0 for exactly GATE_CYCLES cycles, then SETTLE.
- SETTLE: count_ena=0, count_clear=0 for SETTLE_CYCLES cycles, then LATCH.
- LATCH: one cycle. Captures disp*<=count*. Sets overflow<=(count3==4'hE). Next state is CLEAR if run=1, else IDLE.
- run is sampled only in IDLE and LATCH. Deasserting run mid-measurement completes that measurement, including latch and valid.
- disp* and overflow hold their value until the next LATCH.
- Digit values other than 0–9 and 4'hE are latched unchanged. They are not checked.

## Timing
- All outputs are driven directly from flops, with no combinational decode. This is mandatory because count_clear is asynchronous at the counter.
- Reset (rst_n=0 at an edge) gives: state IDLE, count_ena=0, count_clear=1, disp*=0, overflow=0, valid=0, busy=0.
- Reset mid-operation in any state takes effect at the next edge with the values above. No partial latch occurs.
- count_ena is high for exactly GATE_CYCLES consecutive cycles per measurement. It is never high in the same cycle as count_clear.
- count_clear falls in the same edge that count_ena rises.
- valid is high in the cycle after the LATCH cycle, aligned with the new disp* values.
- In continuous mode the period is CLEAR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1 cycles. IDLE is not revisited.
- Latency from run rising in IDLE to count_ena high is 1+CLEAR_CYCLES cycles.
- Timer width is $clog2(max(GATE_CYCLES,CLEAR_CYCLES,SETTLE_CYCLES)+1). The timer never wraps: terminal count is compared against 1 and it reloads on state change.

## Structure
- Shared package freq_pkg holds:
  - state enum (IDLE, CLEAR, GATE, SETTLE, LATCH)
  - OVF_DIGIT = 4'hE
  - the timer-width function, also used by other frequency-meter blocks
- Sub-module cycle_timer:
  - loadable down-counter with parameter WIDTH
  - inputs load and value; output done
- FSM, output flops and result latch live in freq_gate_ctrl.

## Test plan
Parameters for all cases: GATE_CYCLES=10, CLEAR_CYCLES=2, SETTLE_CYCLES=3.
- run=1 from reset release, counter model counting every clk → count_clear high 2 cycles, count_ena high exactly 10 cycles, valid 4 cycles after ena falls; disp=0,0,1,0; overflow=0; the next measurement starts immediately with a 16-cycle period.
- Counter model presents 4'hE on all digits → disp=E,E,E,E; overflow=1. Next measurement with digits 0,1,2,3 → overflow=0.
- run pulsed high for 1 cycle in IDLE → exactly one measurement, one valid pulse, return to IDLE with busy=0 and count_clear=1.
- run dropped during GATE → gate still lasts 10 cycles, latch and valid occur, then IDLE.
- rst_n low for 1 cycle during GATE (cycle 5) and again during SETTLE → next edge: count_ena=0, count_clear=1, disp=0, valid never pulses.
- Assertion over all runs → count_ena and count_clear never both high; valid is only ever a single-cycle pulse.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-meter blocks: controller states,
// the counter overflow code and the timer sizing helper.
package freq_pkg;

  // Measurement sequence of the gate controller.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } state_t;

  // Digit code the BCD counter shows on every digit after it overflows.
  localparam logic [3:0] OVF_DIGIT = 4'hE;

  // Width of a down-counter that must hold the largest of three cycle counts.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter. Reports done on its last counted cycle and then
// parks at zero, so it never wraps while its owner sits in an untimed state.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  // Count register: load wins, otherwise count down and stop at zero.
  // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign done = (cnt == WIDTH'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-timing and result-latch controller for the frequency meter.
// Sequences clear -> gate -> settle -> latch for the downstream BCD counter and
// holds the captured digits stable for the display between measurements.
// Every output comes straight from a flop: count_clear is asynchronous at the
// counter, so a decode glitch on it would corrupt a count.
module freq_gate_ctrl
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES   = 50_000_000,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] count3,
  input  logic [3:0] count2,
  input  logic [3:0] count1,
  input  logic [3:0] count0,
  output logic       count_ena,
  output logic       count_clear,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic       overflow,
  output logic       valid,
  output logic       busy
);

  localparam int TW = timer_width(GATE_CYCLES, CLEAR_CYCLES, SETTLE_CYCLES);

  state_t          state;
  state_t          state_n;
  logic            tmr_load;
  logic [TW-1:0]   tmr_value;
  logic            tmr_done;
  logic            ena_n;
  logic            clear_n;
  logic            busy_n;

  // One timer serves all timed states; it is reloaded on every state change.
  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // Next-state, timer reload and next-output decode.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_n   = state;
    tmr_load  = 1'b0;
    tmr_value = '0;

    case (state)
      IDLE:    if (run)      state_n = CLEAR;
      CLEAR:   if (tmr_done) state_n = GATE;
      GATE:    if (tmr_done) state_n = SETTLE;
      SETTLE:  if (tmr_done) state_n = LATCH;
      LATCH:   state_n = run ? CLEAR : IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n != state) begin
      tmr_load = 1'b1;
      case (state_n)
        CLEAR:   tmr_value = TW'(CLEAR_CYCLES);
        GATE:    tmr_value = TW'(GATE_CYCLES);
        SETTLE:  tmr_value = TW'(SETTLE_CYCLES);
        default: tmr_value = '0;
      endcase
    end

    // Outputs are decoded from the next state and registered below, so the
    // pins change on the same edge as the state with no logic after the flop.
    ena_n   = (state_n == GATE);
    clear_n = (state_n == IDLE) || (state_n == CLEAR);
    busy_n  = (state_n != IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Counter control flops; clear is held high while idle and in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_ena   <= 1'b0;
      count_clear <= 1'b1;
      busy        <= 1'b0;
    end else begin
      count_ena   <= ena_n;
      count_clear <= clear_n;
      busy        <= busy_n;
    end
  end

  // Result latch: capture digits at the end of LATCH, flag valid alongside.
  // NOTE: the result registers are reset because the display reads them directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp3    <= '0;
      disp2    <= '0;
      disp1    <= '0;
      disp0    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= (state == LATCH);
      if (state == LATCH) begin
        disp3    <= count3;
        disp2    <= count2;
        disp1    <= count1;
        disp0    <= count0;
        overflow <= (count3 == OVF_DIGIT);
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl with a behavioural BCD counter model.
module tb_freq_gate_ctrl;

  localparam int GATE_CYCLES   = 10;
  localparam int CLEAR_CYCLES  = 2;
  localparam int SETTLE_CYCLES = 3;
  localparam int PERIOD        = CLEAR_CYCLES + GATE_CYCLES + SETTLE_CYCLES + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] count3, count2, count1, count0;
  logic       count_ena, count_clear;
  logic [3:0] disp3, disp2, disp1, disp0;
  logic       overflow, valid, busy;

  int n_checks = 0;
  int n_fail   = 0;

  freq_gate_ctrl #(
    .GATE_CYCLES   (GATE_CYCLES),
    .CLEAR_CYCLES  (CLEAR_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .count3      (count3),
    .count2      (count2),
    .count1      (count1),
    .count0      (count0),
    .count_ena   (count_ena),
    .count_clear (count_clear),
    .disp3       (disp3),
    .disp2       (disp2),
    .disp1       (disp1),
    .disp0       (disp0),
    .overflow    (overflow),
    .valid       (valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Counter model: async clear, counts in BCD on every enabled clock.
  logic [15:0] mdl;
  logic        use_ovr;
  logic [15:0] ovr_val;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge count_clear) begin
    if (count_clear) mdl <= '0;
    else if (count_ena) mdl <= bcd_inc(mdl);
  end

  assign {count3, count2, count1, count0} = use_ovr ? ovr_val : mdl;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous invariants on every cycle after the first reset.
  logic mon_en = 1'b0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("ena_and_clear_exclusive", 16'(count_ena && count_clear), 16'd0);
      if (prev_valid) check("valid_single_cycle", 16'(valid), 16'd0);
      prev_valid <= valid;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] disp_all();
    return {disp3, disp2, disp1, disp0};
  endfunction

  // Raise run, drop it after 'hold' sampled cycles, observe for ncyc cycles.
  task automatic measure(input int hold, input int ncyc,
                         output int ena_cnt, output int ena_rise, output int vld_cnt,
                         output logic [15:0] d, output logic o);
    logic prev_ena;
    prev_ena = 1'b0;
    ena_cnt  = 0;
    ena_rise = 0;
    vld_cnt  = 0;
    d        = '0;
    o        = 1'b0;
    run      = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      step();
      if (count_ena) ena_cnt++;
      if (count_ena && !prev_ena) ena_rise++;
      prev_ena = count_ena;
      if (valid) begin
        vld_cnt++;
        d = disp_all();
        o = overflow;
      end
      if (i == hold) run = 1'b0;
    end
  endtask

  typedef struct {
    logic        use_ovr;
    logic [15:0] digits;
    logic [15:0] exp_disp;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          ec, er, vc, p;
    logic [15:0] d;
    logic        o;

    vecs[0] = '{1'b0, 16'h0000, 16'h0010, 1'b0};  // live counter, 10 gate cycles
    vecs[1] = '{1'b1, 16'hEEEE, 16'hEEEE, 1'b1};  // counter overflow
    vecs[2] = '{1'b1, 16'h0123, 16'h0123, 1'b0};  // overflow clears next time
    vecs[3] = '{1'b1, 16'hE123, 16'hE123, 1'b1};  // only the top digit decides
    vecs[4] = '{1'b1, 16'hFABC, 16'hFABC, 1'b0};  // non-BCD passed through
    vecs[5] = '{1'b1, 16'h9999, 16'h9999, 1'b0};

    rst_n   = 1'b0;
    run     = 1'b0;
    use_ovr = 1'b0;
    ovr_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;

    // Reset state.
    check("rst_count_ena",   16'(count_ena),   16'd0);
    check("rst_count_clear", 16'(count_clear), 16'd1);
    check("rst_disp",        disp_all(),       16'h0000);
    check("rst_overflow",    16'(overflow),    16'd0);
    check("rst_valid",       16'(valid),       16'd0);
    check("rst_busy",        16'(busy),        16'd0);

    // Continuous mode from reset release: two full periods.
    run = 1'b1;
    step();
    check("rst_holds_idle", 16'(busy), 16'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * PERIOD + 2; k++) begin
      step();
      p = k % PERIOD;
      check("cont_clear", 16'(count_clear), 16'(p < CLEAR_CYCLES));
      check("cont_ena",   16'(count_ena),
            16'(p >= CLEAR_CYCLES && p < CLEAR_CYCLES + GATE_CYCLES));
      check("cont_valid", 16'(valid), 16'(k > 0 && p == 0));
      check("cont_busy",  16'(busy),  16'd1);
      if (k > 0 && p == 0) begin
        check("cont_disp", disp_all(),    16'h0010);
        check("cont_ovf",  16'(overflow), 16'd0);
      end
    end
    run = 1'b0;
    repeat (PERIOD + 4) step();
    check("cont_stop_busy",  16'(busy),        16'd0);
    check("cont_stop_clear", 16'(count_clear), 16'd1);

    // Table-driven single measurements started by a one-cycle run pulse.
    foreach (vecs[v]) begin
      use_ovr = vecs[v].use_ovr;
      ovr_val = vecs[v].digits;
      measure(1, PERIOD + 8, ec, er, vc, d, o);
      check($sformatf("vec%0d_ena_cycles", v), 16'(ec), 16'(GATE_CYCLES));
      check($sformatf("vec%0d_ena_rises", v),  16'(er), 16'd1);
      check($sformatf("vec%0d_valid_cnt", v),  16'(vc), 16'd1);
      check($sformatf("vec%0d_disp", v),       d,       vecs[v].exp_disp);
      check($sformatf("vec%0d_ovf", v),        16'(o),  16'(vecs[v].exp_ovf));
      check($sformatf("vec%0d_idle_busy", v),  16'(busy), 16'd0);
      check($sformatf("vec%0d_idle_clear", v), 16'(count_clear), 16'd1);
      check($sformatf("vec%0d_hold_disp", v),  disp_all(), vecs[v].exp_disp);
    end

    // run dropped in the middle of the gate: measurement still completes.
    use_ovr = 1'b0;
    measure(6, PERIOD + 8, ec, er, vc, d, o);
    check("drop_ena_cycles", 16'(ec),   16'(GATE_CYCLES));
    check("drop_valid_cnt",  16'(vc),   16'd1);
    check("drop_disp",       d,         16'h0010);
    check("drop_busy",       16'(busy), 16'd0);

    // Reset during the 5th gate cycle.
    use_ovr = 1'b1;
    ovr_val = 16'h9876;
    run     = 1'b1;
    for (int i = 1; i <= CLEAR_CYCLES + 5; i++) step();
    check("pre_gate_rst_ena", 16'(count_ena), 16'd1);
    rst_n = 1'b0;
    run   = 1'b0;
    step();
    check("gate_rst_ena",   16'(count_ena),   16'd0);
    check("gate_rst_clear", 16'(count_clear), 16'd1);
    check("gate_rst_disp",  disp_all(),       16'h0000);
    check("gate_rst_busy",  16'(busy),        16'd0);
    rst_n = 1'b1;
    vc = 0;
    for (int i = 0; i < PERIOD + 4; i++) begin
      step();
      if (valid) vc++;
    end
    check("gate_rst_no_valid", 16'(vc), 16'd0);
    check("gate_rst_disp_kept", disp_all(), 16'h0000);

    // Fresh result, then reset during settle.
    ovr_val = 16'h4321;
    measure(1, PERIOD + 8, ec, er, vc, d, o);
    check("pre_settle_disp", d, 16'h4321);
    run = 1'b1;
    for (int i = 1; i <= CLEAR_CYCLES + GATE_CYCLES + 2; i++) step();
    check("pre_settle_rst_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    run   = 1'b0;
    step();
    check("settle_rst_ena",   16'(count_ena),   16'd0);
    check("settle_rst_clear", 16'(count_clear), 16'd1);
    check("settle_rst_disp",  disp_all(),       16'h0000);
    check("settle_rst_valid", 16'(valid),       16'd0);
    rst_n = 1'b1;
    vc = 0;
    for (int i = 0; i < PERIOD + 4; i++) begin
      step();
      if (valid) vc++;
    end
    check("settle_rst_no_valid", 16'(vc), 16'd0);
    check("settle_rst_disp_kept", disp_all(), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
